// File: rtl/mantle_serialize_arr_if.sv
// Bundle between the array producer and the word-serial consumer of mantle_serialize_arr.
// Optional out_idx is present only when MANTLE_SERIALIZE_IDX_EN is defined.
interface mantle_serialize_arr_if #(
  parameter int N = 22,
  parameter int W = 32
);
  // Handshake: an array (in_*) or a word (out_*) moves on a CLK rising edge where valid && ready
  // are both high; out_valid/out_data/out_last stay stable until accepted, and in_ready may
  // follow out_ready combinationally while the final word of an array is on the output.
  logic [W-1:0] in_data [N-1:0];
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         dbg_busy;

`ifdef MANTLE_SERIALIZE_IDX_EN
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [IW-1:0] out_idx;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, dbg_busy, out_idx
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, dbg_busy, out_idx
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, dbg_busy
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, dbg_busy
  );
`endif
endinterface

// File: rtl/mantle_serialize_arr.sv
// Captures one N-word array per handshake and replays it word 0 first, flagging the last word.
// Define MANTLE_SERIALIZE_IDX_EN to drive out_idx with the index of the word on the output.
module mantle_serialize_arr #(
  parameter int N = 22,
  parameter int W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mantle_serialize_arr_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  buf_q [N-1:0];
  logic          load;
  logic          is_last;
  logic          in_ready_c;

  assign is_last = (idx_q == LAST_IDX);

  // A new array is only taken while idle or as the final word leaves, so no bubble between arrays.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    load       = 1'b0;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.out_ready) begin
          if (is_last) begin
            in_ready_c = 1'b1;
            idx_d      = '0;
            if (bus.in_valid) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int k = 0; k < N; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        for (int k = 0; k < N; k++) begin
          buf_q[k] <= bus.in_data[k];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == BUSY);
  assign bus.out_data  = buf_q[idx_q];
  assign bus.out_last  = (state_q == BUSY) && is_last;
  assign bus.dbg_busy  = (state_q == BUSY);

`ifdef MANTLE_SERIALIZE_IDX_EN
  assign bus.out_idx = idx_q;
`endif

endmodule

// File: tb/tb_mantle_serialize_arr.sv
// Bench for mantle_serialize_arr: N=22/W=32 instance against a word-queue model, plus an N=1/W=8 instance.
module tb_mantle_serialize_arr;
  localparam int N  = 22;
  localparam int W  = 32;
  localparam int N1 = 1;
  localparam int W1 = 8;

  logic CLK;
  logic RESET;

  mantle_serialize_arr_if #(.N(N),  .W(W))  if22 ();
  mantle_serialize_arr_if #(.N(N1), .W(W1)) if1 ();

  mantle_serialize_arr #(.N(N), .W(W)) u_dut22 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if22)
  );

  mantle_serialize_arr #(.N(N1), .W(W1)) u_dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (if1)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] nxt_data [N];
  logic         cur_rst, cur_iv, cur_or;

  // ---------------- driver ----------------
  task automatic drive22(input logic rst, input logic iv, input logic orr);
    @(negedge CLK);
    RESET          = rst;
    if22.in_valid  = iv;
    if22.out_ready = orr;
    for (int k = 0; k < N; k++) if22.in_data[k] = nxt_data[k];
    cur_rst = rst;
    cur_iv  = iv;
    cur_or  = orr;
    #1;
  endtask

  task automatic stage_seq(input logic [W-1:0] base);
    for (int k = 0; k < N; k++) nxt_data[k] = base + W'(k);
  endtask

  task automatic stage_rand();
    for (int k = 0; k < N; k++) nxt_data[k] = $urandom;
  endtask

  // ---------------- reference model ----------------
  // The queue holds the words of the array still owed to the consumer, oldest first.
  task automatic expect22(output logic ev, output logic er, output logic [W-1:0] ed, output logic el);
    ev = (exp_q.size() > 0);
    er = (exp_q.size() == 0) || (cur_or && exp_q.size() == 1);
    ed = '0;
    if (ev) ed = exp_q[0];
    el = (exp_q.size() == 1);
  endtask

  task automatic advance22(output logic cap, output logic ohs);
    int rem;
    rem = exp_q.size();
    cap = 1'b0;
    ohs = 1'b0;
    if (cur_rst) begin
      exp_q.delete();
      return;
    end
    ohs = (rem > 0) && cur_or;
    cap = cur_iv && ((rem == 0) || (cur_or && rem == 1));
    if (ohs) void'(exp_q.pop_front());
    if (cap) for (int k = 0; k < N; k++) exp_q.push_back(if22.in_data[k]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic cap, ohs;
    stage_rand();
    for (int c = 0; c < 3; c++) begin
      drive22(1'b1, 1'b1, 1'b1);
      advance22(cap, ohs);
    end
    drive22(1'b0, 1'b0, 1'b0);
    n_cmp++; if (if22.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.out_valid got=%b exp=0", if22.out_valid); end
    n_cmp++; if (if22.in_ready !== 1'b1) begin n_err++; $display("FAIL reset.in_ready got=%b exp=1", if22.in_ready); end
    n_cmp++; if (if22.out_last !== 1'b0) begin n_err++; $display("FAIL reset.out_last got=%b exp=0", if22.out_last); end
    n_cmp++; if (if22.out_data !== '0) begin n_err++; $display("FAIL reset.out_data got=%h exp=0", if22.out_data); end
    advance22(cap, ohs);
    drive22(1'b0, 1'b0, 1'b1);
    n_cmp++; if (if22.out_valid !== 1'b0) begin n_err++; $display("FAIL reset.no_capture out_valid got=%b exp=0", if22.out_valid); end
    advance22(cap, ohs);
  endtask

  task automatic test_basic();
    logic ev, er, el, cap, ohs;
    logic [W-1:0] ed;
    stage_seq(32'h1000);
    for (int c = 0; c <= N + 1; c++) begin
      drive22(1'b0, (c == 0), 1'b1);
      expect22(ev, er, ed, el);
      n_cmp++; if (if22.out_valid !== ev) begin n_err++; $display("FAIL basic.out_valid c=%0d got=%b exp=%b", c, if22.out_valid, ev); end
      n_cmp++; if (if22.in_ready !== er) begin n_err++; $display("FAIL basic.in_ready c=%0d got=%b exp=%b", c, if22.in_ready, er); end
      n_cmp++; if (if22.out_last !== (ev && el)) begin n_err++; $display("FAIL basic.out_last c=%0d got=%b exp=%b", c, if22.out_last, ev && el); end
      if (ev) begin
        n_cmp++; if (if22.out_data !== ed) begin n_err++; $display("FAIL basic.out_data c=%0d got=%h exp=%h", c, if22.out_data, ed); end
`ifdef MANTLE_SERIALIZE_IDX_EN
        n_cmp++; if (if22.out_idx !== 5'(N - exp_q.size())) begin n_err++; $display("FAIL basic.out_idx c=%0d got=%0d exp=%0d", c, if22.out_idx, N - exp_q.size()); end
`endif
      end
      advance22(cap, ohs);
    end
  endtask

  task automatic test_backpressure();
    logic ev, er, el, cap, ohs;
    logic [W-1:0] ed;
    logic [3:0] pat;
    int words;
    pat   = 4'b1001;
    words = 0;
    stage_seq(32'h1000);
    for (int c = 0; c < 200; c++) begin
      drive22(1'b0, (c == 0), pat[c % 4]);
      expect22(ev, er, ed, el);
      n_cmp++; if (if22.out_valid !== ev) begin n_err++; $display("FAIL bp.out_valid c=%0d got=%b exp=%b", c, if22.out_valid, ev); end
      n_cmp++; if (if22.in_ready !== er) begin n_err++; $display("FAIL bp.in_ready c=%0d got=%b exp=%b", c, if22.in_ready, er); end
      n_cmp++; if (if22.out_last !== (ev && el)) begin n_err++; $display("FAIL bp.out_last c=%0d got=%b exp=%b", c, if22.out_last, ev && el); end
      if (ev) begin
        n_cmp++; if (if22.out_data !== ed) begin n_err++; $display("FAIL bp.out_data c=%0d got=%h exp=%h", c, if22.out_data, ed); end
      end
      if (if22.out_valid === 1'b1 && if22.out_ready === 1'b1) words++;
      advance22(cap, ohs);
      if (c > 0 && exp_q.size() == 0) break;
    end
    n_cmp++; if (words != N) begin n_err++; $display("FAIL bp.word_count got=%0d exp=%0d", words, N); end
  endtask

  task automatic test_back_to_back();
    logic ev, er, el, cap, ohs, hold;
    logic [W-1:0] ed;
    int rdy_hits, t_last, t_first2;
    stage_seq(32'h1000);
    drive22(1'b0, 1'b1, 1'b1);
    advance22(cap, ohs);
    stage_seq(32'h2000);
    hold = 1'b1; rdy_hits = 0; t_last = -1; t_first2 = -1;
    for (int c = 1; c <= 60; c++) begin
      drive22(1'b0, hold, 1'b1);
      expect22(ev, er, ed, el);
      n_cmp++; if (if22.out_valid !== ev) begin n_err++; $display("FAIL b2b.out_valid c=%0d got=%b exp=%b", c, if22.out_valid, ev); end
      n_cmp++; if (if22.in_ready !== er) begin n_err++; $display("FAIL b2b.in_ready c=%0d got=%b exp=%b", c, if22.in_ready, er); end
      n_cmp++; if (if22.out_last !== (ev && el)) begin n_err++; $display("FAIL b2b.out_last c=%0d got=%b exp=%b", c, if22.out_last, ev && el); end
      if (ev) begin
        n_cmp++; if (if22.out_data !== ed) begin n_err++; $display("FAIL b2b.out_data c=%0d got=%h exp=%h", c, if22.out_data, ed); end
      end
      if (hold && if22.in_ready === 1'b1) rdy_hits++;
      if (if22.out_valid === 1'b1 && if22.out_data === 32'h1015) t_last = c;
      if (if22.out_valid === 1'b1 && if22.out_data === 32'h2000 && t_first2 < 0) t_first2 = c;
      advance22(cap, ohs);
      if (cap) hold = 1'b0;
    end
    n_cmp++; if (rdy_hits != 1) begin n_err++; $display("FAIL b2b.in_ready_pulses got=%0d exp=1", rdy_hits); end
    n_cmp++; if (t_last < 0 || t_first2 != t_last + 1) begin n_err++; $display("FAIL b2b.gap last_at=%0d first2_at=%0d exp_gap=1", t_last, t_first2); end
  endtask

  task automatic test_mid_reset();
    logic ev, er, el, cap, ohs;
    logic [W-1:0] ed;
    int xfers;
    xfers = 0;
    stage_rand();
    drive22(1'b0, 1'b1, 1'b1);
    advance22(cap, ohs);
    for (int c = 0; c < 10 && xfers < 6; c++) begin
      drive22(1'b0, 1'b0, 1'b1);
      expect22(ev, er, ed, el);
      n_cmp++; if (if22.out_data !== ed) begin n_err++; $display("FAIL midrst.pre_data c=%0d got=%h exp=%h", c, if22.out_data, ed); end
      advance22(cap, ohs);
      if (ohs) xfers++;
    end
    drive22(1'b1, 1'b0, 1'b1);
    advance22(cap, ohs);
    drive22(1'b0, 1'b0, 1'b1);
    n_cmp++; if (if22.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst.out_valid got=%b exp=0", if22.out_valid); end
    n_cmp++; if (if22.in_ready !== 1'b1) begin n_err++; $display("FAIL midrst.in_ready got=%b exp=1", if22.in_ready); end
    advance22(cap, ohs);
    stage_rand();
    for (int c = 0; c <= N + 1; c++) begin
      drive22(1'b0, (c == 0), 1'b1);
      expect22(ev, er, ed, el);
      n_cmp++; if (if22.out_valid !== ev) begin n_err++; $display("FAIL midrst.out_valid c=%0d got=%b exp=%b", c, if22.out_valid, ev); end
      n_cmp++; if (if22.out_last !== (ev && el)) begin n_err++; $display("FAIL midrst.out_last c=%0d got=%b exp=%b", c, if22.out_last, ev && el); end
      if (ev) begin
        n_cmp++; if (if22.out_data !== ed) begin n_err++; $display("FAIL midrst.out_data c=%0d got=%h exp=%h", c, if22.out_data, ed); end
      end
      advance22(cap, ohs);
    end
  endtask

  task automatic test_random();
    logic ev, er, el, cap, ohs, iv, orr;
    logic [W-1:0] ed;
    for (int c = 0; c < 400 + N + 2; c++) begin
      stage_rand();
      iv  = (c < 400) ? ($urandom_range(0, 2) == 0) : 1'b0;
      orr = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b1;
      drive22(1'b0, iv, orr);
      expect22(ev, er, ed, el);
      n_cmp++; if (if22.out_valid !== ev) begin n_err++; $display("FAIL rand.out_valid c=%0d got=%b exp=%b", c, if22.out_valid, ev); end
      n_cmp++; if (if22.in_ready !== er) begin n_err++; $display("FAIL rand.in_ready c=%0d got=%b exp=%b", c, if22.in_ready, er); end
      n_cmp++; if (if22.out_last !== (ev && el)) begin n_err++; $display("FAIL rand.out_last c=%0d got=%b exp=%b", c, if22.out_last, ev && el); end
      if (ev) begin
        n_cmp++; if (if22.out_data !== ed) begin n_err++; $display("FAIL rand.out_data c=%0d got=%h exp=%h", c, if22.out_data, ed); end
      end
      advance22(cap, ohs);
    end
  endtask

  task automatic test_n1();
    logic [W1-1:0] vals [3];
    logic exp_v;
    vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if1.in_valid  = (i < 3);
      if1.out_ready = 1'b1;
      if (i < 3) if1.in_data[0] = vals[i];
      #1;
      exp_v = (i >= 1) && (i <= 3);
      n_cmp++; if (if1.in_ready !== 1'b1) begin n_err++; $display("FAIL n1.in_ready i=%0d got=%b exp=1", i, if1.in_ready); end
      n_cmp++; if (if1.out_valid !== exp_v) begin n_err++; $display("FAIL n1.out_valid i=%0d got=%b exp=%b", i, if1.out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (if1.out_data !== vals[i-1]) begin n_err++; $display("FAIL n1.out_data i=%0d got=%h exp=%h", i, if1.out_data, vals[i-1]); end
        n_cmp++; if (if1.out_last !== 1'b1) begin n_err++; $display("FAIL n1.out_last i=%0d got=%b exp=1", i, if1.out_last); end
`ifdef MANTLE_SERIALIZE_IDX_EN
        n_cmp++; if (if1.out_idx !== 1'b0) begin n_err++; $display("FAIL n1.out_idx i=%0d got=%0d exp=0", i, if1.out_idx); end
`endif
      end
    end
    @(negedge CLK);
    if1.in_valid = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RESET          = 1'b1;
    if22.in_valid  = 1'b0;
    if22.out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if22.in_data[k] = '0;
      nxt_data[k]     = '0;
    end
    if1.in_valid   = 1'b0;
    if1.out_ready  = 1'b0;
    if1.in_data[0] = '0;
    cur_rst = 1'b1; cur_iv = 1'b0; cur_or = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_n1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mantle_serialize_arr.md
Name: mantle_serialize_arr

Overview:
- Downstream stage of the N-input array concatenator.
- Accepts one complete N-word array (each word W bits) per valid/ready transaction.
- Buffers it, then emits it one word per cycle on a valid/ready stream, word 0 first, flagging the final word.
- Feeds narrow word-serial consumers (memory write ports, streaming links) from the concatenated array.

Parameters:
- N, 22, number of words per array (N >= 1)
- W, 32, bits per word
- IW, max(1, clog2(N)), word-index width (derived; not overridden)

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous active-high reset
- in_data  input  N x W (unpacked array [N-1:0] of [W-1:0])  array to serialize; element 0 is sent first
- in_valid  input  1  in_data valid
- in_ready  output  1  block can capture in_data this cycle
- out_data  output  W  current word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_last  output  1  high with out_valid on word N-1

Interface (already decided):
- One clock, CLK.
- RESET is synchronous and active-high.
- All state is sampled on CLK rising edge.

Behaviour:
- Storage: N x W buffer register; IW-bit index register idx; 1-bit state {IDLE, BUSY}.
- Reset (RESET high at clock edge):
  - state = IDLE, idx = 0.
  - out_valid = 0, out_last = 0, out_data = 0 (buffer cleared to 0).
  - in_ready = 1 in the cycle after reset.
  - RESET overrides all handshakes in that cycle. A word in flight mid-array is dropped, and no partial array resumes.
- Handshake: a transfer occurs when valid && ready at the clock edge. out_data and out_valid must not depend combinationally on in_*.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: capture all N words, idx = 0, go to BUSY.
- BUSY:
  - out_valid = 1.
  - out_data = buffer[idx].
  - out_last = (idx == N-1).
  - Output held stable while out_ready = 0.
  - On output transfer with idx < N-1: idx += 1.
  - On output transfer with idx == N-1 (last word):
    - If in_valid: capture the new array, idx = 0, stay BUSY. This gives back-to-back arrays with no bubble.
    - Else: go to IDLE, idx = 0.
- in_ready in BUSY = out_ready && (idx == N-1). This is a combinational path from out_ready; it is documented and intentional.
- Latency:
  - First word valid 1 cycle after input capture.
  - Throughput is one word per cycle when out_ready is held high.
  - An array occupies exactly N output-handshake cycles.
- N = 1: every word is last. in_ready in BUSY = out_ready; steady state is one array per cycle.
- idx never exceeds N-1; no wrap beyond N-1 is reachable.
- Buffer contents are unchanged except on input capture. in_data changes while BUSY are ignored.

Optional Feature:
- Macro: MANTLE_SERIALIZE_IDX_EN.
- Defined:
  - Adds output port out_idx (IW bits) = idx, valid when out_valid = 1.
  - out_idx resets to 0.
  - Used by consumers that compute a write address.
- Undefined:
  - Port absent.
  - Behaviour otherwise identical.

Test Plan:
- Reset, then hold RESET for 3 cycles with in_valid = 1 -> out_valid = 0 and in_ready = 1 after release; nothing captured.
- N = 22, W = 32:
  - Stimulus: in_data[k] = 0x1000 + k, in_valid pulsed 1 cycle, out_ready = 1.
  - Required: words 0x1000..0x1015 on 22 consecutive cycles starting 1 cycle after capture.
  - out_last only on 0x1015; out_valid = 0 on the following cycle.
- Backpressure:
  - Stimulus: out_ready toggled 1,0,0,1 pattern.
  - Required: out_data stable while out_ready = 0; no word skipped or duplicated; all 22 words arrive in order.
- Back-to-back:
  - Stimulus: second array (0x2000 + k) presented with in_valid held high during first array.
  - Required: in_ready high only in the cycle of 0x1015's transfer; 0x2000 follows 0x1015 with zero bubble cycles.
- Mid-array reset:
  - Stimulus: assert RESET after word 5 transfers.
  - Required: next cycle out_valid = 0 and in_ready = 1. A new array restarts from its word 0.
- N = 1, W = 8:
  - Stimulus: in_valid and out_ready held high, inputs 0xA5, 0x5A, 0x3C.
  - Required: one word per cycle, each with out_last = 1. With MANTLE_SERIALIZE_IDX_EN defined, out_idx = 0 throughout.
